// File: rtl/cpu_types_pkg.sv
// Shared types for the memory arbiter: RAM handshake state, data word and arbiter FSM state.
package cpu_types_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   // RAM handshake reported back to the arbiter every cycle
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Which requester currently owns the RAM port
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IGRANT = 2'd1,
      DGRANT = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter.
//   slave  : arbiter view (takes requests and RAM status, drives hits and RAM controls)
//   master : environment view (fetch/data requesters and the RAM)
interface mem_arbiter_if
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   import cpu_types_pkg::*;

   // instruction fetch port
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              ihit;
   logic [DATA_W-1:0] iload;
   // data port
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic              dhit;
   logic [DATA_W-1:0] dload;
   // RAM port
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic [DATA_W-1:0] ramload;
   ramstate_t         ramstate;
   // abort indication
   logic              mem_err;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
   );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between the fetch and data requesters of the core.
// One request is latched at a time and sequenced to RAM; completion is a one-cycle
// ihit/dhit pulse. Data wins arbitration unless fetch has been starved STARVE_MAX times.
// Ports:
//   CLK, nRST : clock (rising edge) and asynchronous active-low reset
//   bus       : mem_arbiter_if.slave -- fetch request/hit, data request/hit,
//               RAM enables/address/store/load/state, mem_err abort pulse
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic         CLK,
   input  logic         nRST,
   mem_arbiter_if.slave bus
);

   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
   localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

   arb_state_t          state_q, state_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic                ram_ren_q, ram_ren_d;
   logic                ram_wen_q, ram_wen_d;
   logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0]   ram_store_q, ram_store_d;
   logic                ihit_q, ihit_d;
   logic                dhit_q, dhit_d;
   logic [DATA_W-1:0]   iload_q, iload_d;
   logic [DATA_W-1:0]   dload_q, dload_d;
   logic                mem_err_q, mem_err_d;

   logic d_req;
   logic force_fetch;
   logic tmo_expired;

   assign d_req       = bus.dREN | bus.dWEN;
   // fetch has waited through STARVE_MAX data grants: it must win this arbitration
   assign force_fetch = bus.iREN && (starve_q == STARVE_W'(STARVE_MAX));
   // tmo_q counts wait edges already spent; this edge is the TIMEOUT-th one
   assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));

   // Arbitration, grant sequencing and completion
   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      tmo_d       = tmo_q;
      ram_ren_d   = ram_ren_q;
      ram_wen_d   = ram_wen_q;
      ram_addr_d  = ram_addr_q;
      ram_store_d = ram_store_q;
      iload_d     = iload_q;
      dload_d     = dload_q;
      ihit_d      = 1'b0;
      dhit_d      = 1'b0;
      mem_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (d_req && !force_fetch) begin
               state_d     = DGRANT;
               tmo_d       = '0;
               // both enables high is a write
               ram_wen_d   = bus.dWEN;
               ram_ren_d   = !bus.dWEN;
               ram_addr_d  = bus.daddr;
               ram_store_d = bus.dWEN ? bus.dstore : '0;
               if (!bus.iREN) begin
                  starve_d = '0;
               end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
                  starve_d = starve_q + STARVE_W'(1);
               end
            end else if (bus.iREN) begin
               state_d     = IGRANT;
               tmo_d       = '0;
               starve_d    = '0;
               ram_ren_d   = 1'b1;
               ram_wen_d   = 1'b0;
               ram_addr_d  = bus.iaddr;
               ram_store_d = '0;
            end
         end

         IGRANT, DGRANT: begin
            if (bus.ramstate == ACCESS) begin
               state_d   = IDLE;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               if (state_q == IGRANT) begin
                  ihit_d  = 1'b1;
                  iload_d = bus.ramload;
               end else begin
                  dhit_d  = 1'b1;
                  dload_d = ram_wen_q ? '0 : bus.ramload;
               end
            end else if ((bus.ramstate == ERROR) || tmo_expired) begin
               state_d   = IDLE;
               ram_ren_d = 1'b0;
               ram_wen_d = 1'b0;
               mem_err_d = 1'b1;
            end else begin
               // FREE/BUSY: keep waiting
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         default: begin
            state_d   = IDLE;
            ram_ren_d = 1'b0;
            ram_wen_d = 1'b0;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         starve_q    <= '0;
         tmo_q       <= '0;
         ram_ren_q   <= 1'b0;
         ram_wen_q   <= 1'b0;
         ram_addr_q  <= '0;
         ram_store_q <= '0;
         ihit_q      <= 1'b0;
         dhit_q      <= 1'b0;
         iload_q     <= '0;
         dload_q     <= '0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         tmo_q       <= tmo_d;
         ram_ren_q   <= ram_ren_d;
         ram_wen_q   <= ram_wen_d;
         ram_addr_q  <= ram_addr_d;
         ram_store_q <= ram_store_d;
         ihit_q      <= ihit_d;
         dhit_q      <= dhit_d;
         iload_q     <= iload_d;
         dload_q     <= dload_d;
         mem_err_q   <= mem_err_d;
      end
   end

   assign bus.ramREN   = ram_ren_q;
   assign bus.ramWEN   = ram_wen_q;
   assign bus.ramaddr  = ram_addr_q;
   assign bus.ramstore = ram_store_q;
   assign bus.ihit     = ihit_q;
   assign bus.dhit     = dhit_q;
   assign bus.iload    = iload_q;
   assign bus.dload    = dload_q;
   assign bus.mem_err  = mem_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level requester/RAM model.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   localparam int STARVE_MAX = 4;
   localparam int TIMEOUT    = 255;

   logic clk;
   logic n_rst;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK  (clk),
      .nRST (n_rst),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // RAM contents (what the RAM holds) and reference contents (what the core expects)
   logic [31:0] ram_mem [256];
   logic [31:0] ref_mem [256];
   int          ram_lat  = 1;   // cycles with an enable high before ACCESS
   int          ram_mode = 0;   // 0 normal, 1 stuck BUSY, 2 ERROR
   int          ram_cnt  = 0;

   function automatic int unsigned idx(input logic [31:0] a);
      return 32'(a[9:2]);
   endfunction

   function automatic logic [31:0] init_word(input int i);
      if (i == 16) return 32'h2001_0005;
      if (i == 64) return 32'h1234_5678;
      return 32'(i) * 32'h9E37_79B9 + 32'h0000_1357;
   endfunction

   // RAM responder: reports ACCESS after ram_lat enabled cycles, writes on ACCESS
   initial begin
      bus.ramstate = FREE;
      bus.ramload  = '0;
      for (int i = 0; i < 256; i++) ram_mem[i] = init_word(i);
      forever begin
         @(negedge clk);
         if (bus.ramREN || bus.ramWEN) begin
            ram_cnt = ram_cnt + 1;
            if (ram_mode == 2) begin
               bus.ramstate = ERROR;
            end else if (ram_mode == 0 && ram_cnt >= ram_lat) begin
               bus.ramstate = ACCESS;
               if (bus.ramWEN) begin
                  ram_mem[idx(bus.ramaddr)] = bus.ramstore;
                  bus.ramload = $urandom;
               end else begin
                  bus.ramload = ram_mem[idx(bus.ramaddr)];
               end
            end else begin
               bus.ramstate = BUSY;
            end
         end else begin
            ram_cnt      = 0;
            bus.ramstate = FREE;
            bus.ramload  = $urandom;
         end
      end
   end

   // requester / scoreboard state
   logic [31:0] i_addr_req, d_addr_req, d_store_req;
   logic        d_wr_req;
   logic        prev_en;
   logic [31:0] last_iload, last_dload;
   logic        g_wen;
   logic [31:0] g_addr, g_store;
   int cyc, streak, gr, en_cnt;
   int i_hits, d_hits, errs;
   int i_issue_cyc, d_issue_cyc, i_hit_cyc, d_hit_cyc, err_cyc;
   int hit_en_len, err_en_len, d_hits_at_ihit;
   bit d_hold, rand_on, err_expected;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue_i(input logic [31:0] a);
      bus.iREN    = 1'b1;
      bus.iaddr   = a;
      i_addr_req  = a;
      i_issue_cyc = cyc;
   endtask

   task automatic issue_d(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] s);
      bus.dREN    = rd;
      bus.dWEN    = wr;
      bus.daddr   = a;
      bus.dstore  = s;
      d_addr_req  = a;
      d_store_req = s;
      d_wr_req    = wr;
      d_issue_cyc = cyc;
   endtask

   // One cycle: observe outputs mid-cycle, check against the model, then drive requests
   task automatic step();
      logic i_was, d_was, en, exp_i;
      @(negedge clk);
      cyc++;
      i_was = bus.iREN;
      d_was = bus.dREN | bus.dWEN;
      en    = bus.ramREN | bus.ramWEN;

      chk("hit_exclusive", 64'(bus.ihit & bus.dhit), 64'(0));
      if (!err_expected) chk("spurious_err", 64'(bus.mem_err), 64'(0));

      if (en && !prev_en) begin
         chk("grant_has_request", 64'(i_was | d_was), 64'(1));
         exp_i = i_was && (!d_was || (streak == STARVE_MAX));
         chk("grant_addr", 64'(bus.ramaddr), 64'(exp_i ? i_addr_req : d_addr_req));
         chk("grant_wen", 64'(bus.ramWEN), 64'(!exp_i && d_wr_req));
         chk("grant_ren", 64'(bus.ramREN), 64'(exp_i || !d_wr_req));
         if (!exp_i && d_wr_req) chk("grant_store", 64'(bus.ramstore), 64'(d_store_req));
         g_wen   = bus.ramWEN;
         g_addr  = bus.ramaddr;
         g_store = bus.ramstore;
         if (exp_i)       streak = 0;
         else if (i_was)  streak = (streak < STARVE_MAX) ? streak + 1 : streak;
         else             streak = 0;
         gr     = exp_i ? 1 : 2;
         en_cnt = 0;
      end
      if (en) en_cnt++;
      prev_en = en;

      if (bus.ihit) begin
         chk("ihit_owner", 64'(gr), 64'(1));
         chk("iload", 64'(bus.iload), 64'(ref_mem[idx(i_addr_req)]));
         last_iload     = ref_mem[idx(i_addr_req)];
         i_hits++;
         i_hit_cyc      = cyc;
         hit_en_len     = en_cnt;
         d_hits_at_ihit = d_hits;
         gr             = 0;
         bus.iREN       = 1'b0;
      end else begin
         chk("iload_hold", 64'(bus.iload), 64'(last_iload));
      end

      if (bus.dhit) begin
         chk("dhit_owner", 64'(gr), 64'(2));
         if (d_wr_req) begin
            chk("dload_on_write", 64'(bus.dload), 64'(0));
            ref_mem[idx(d_addr_req)] = d_store_req;
            last_dload = '0;
         end else begin
            chk("dload", 64'(bus.dload), 64'(ref_mem[idx(d_addr_req)]));
            last_dload = ref_mem[idx(d_addr_req)];
         end
         d_hits++;
         d_hit_cyc  = cyc;
         hit_en_len = en_cnt;
         gr         = 0;
         if (!d_hold) begin
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
         end
      end else begin
         chk("dload_hold", 64'(bus.dload), 64'(last_dload));
      end

      if (bus.mem_err) begin
         errs++;
         err_cyc    = cyc;
         err_en_len = en_cnt;
         if (gr == 1) bus.iREN = 1'b0;
         if (gr == 2) begin
            bus.dREN = 1'b0;
            bus.dWEN = 1'b0;
         end
         gr = 0;
      end

      if (rand_on) begin
         if (!bus.iREN && $urandom_range(0, 2) == 0)
            issue_i({23'd0, 7'($urandom_range(0, 127)), 2'b00});
         if (!bus.dREN && !bus.dWEN && $urandom_range(0, 2) == 0) begin
            int r;
            r = $urandom_range(0, 3);
            issue_d(r == 1 || r == 2, r != 1, 32'h200 | {23'd0, 7'($urandom_range(0, 127)), 2'b00}, $urandom);
         end
         if (!(bus.ramREN | bus.ramWEN)) ram_lat = $urandom_range(1, 3);
      end
   endtask

   int bi, bd, be;

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      cyc = 0; streak = 0; gr = 0; en_cnt = 0; prev_en = 1'b0;
      i_hits = 0; d_hits = 0; errs = 0;
      last_iload = '0; last_dload = '0;
      d_hold = 1'b0; rand_on = 1'b0; err_expected = 1'b0;
      d_wr_req = 1'b0; i_addr_req = '0; d_addr_req = '0; d_store_req = '0;
      bus.iREN = 1'b0; bus.iaddr = '0;
      bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
      n_rst = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_ramREN", 64'(bus.ramREN), 64'(0));
      chk("rst_ramWEN", 64'(bus.ramWEN), 64'(0));
      chk("rst_hits", 64'({bus.ihit, bus.dhit, bus.mem_err}), 64'(0));
      chk("rst_loads", 64'({bus.iload, bus.dload}), 64'(0));
      chk("rst_ram_bus", 64'({bus.ramaddr, bus.ramstore}), 64'(0));
      n_rst = 1'b1;

      // lone fetch, RAM latency 2
      ram_lat = 2; bi = i_hits; bd = d_hits;
      issue_i(32'h0000_0040);
      repeat (8) step();
      chk("fetch_hits", 64'(i_hits - bi), 64'(1));
      chk("fetch_no_dhit", 64'(d_hits - bd), 64'(0));
      chk("fetch_iload", 64'(last_iload), 64'(32'h2001_0005));
      chk("fetch_ren_cycles", 64'(hit_en_len), 64'(2));
      chk("fetch_latency", 64'(i_hit_cyc - i_issue_cyc), 64'(3));

      // simultaneous fetch and data read: data first, minimum latency
      ram_lat = 1; bi = i_hits; bd = d_hits;
      issue_i(32'h0000_0040);
      issue_d(1'b0, 1'b1, 32'h0000_0100, '0);
      repeat (8) step();
      chk("both_dhit", 64'(d_hits - bd), 64'(1));
      chk("both_ihit", 64'(i_hits - bi), 64'(1));
      chk("both_d_latency", 64'(d_hit_cyc - d_issue_cyc), 64'(2));
      chk("both_i_after_d", 64'((i_hit_cyc - d_hit_cyc) >= 2), 64'(1));
      chk("both_dload", 64'(last_dload), 64'(32'h1234_5678));

      // starvation: data held continuously, fetch forced after STARVE_MAX data grants
      bi = i_hits; bd = d_hits; d_hold = 1'b1;
      issue_i(32'h0000_0080);
      issue_d(1'b0, 1'b1, 32'h0000_0300, '0);
      for (int k = 0; k < 60 && i_hits == bi; k++) step();
      chk("starve_ihit", 64'(i_hits - bi), 64'(1));
      chk("starve_dhits_first", 64'(d_hits_at_ihit - bd), 64'(STARVE_MAX));
      d_hold = 1'b0; bus.dREN = 1'b0;
      repeat (6) step();

      // write, then read it back
      ram_lat = 2; bd = d_hits;
      issue_d(1'b1, 1'b0, 32'h0000_0200, 32'hDEAD_BEEF);
      repeat (6) step();
      chk("wr_dhit", 64'(d_hits - bd), 64'(1));
      chk("wr_ramWEN", 64'(g_wen), 64'(1));
      chk("wr_ramaddr", 64'(g_addr), 64'(32'h0000_0200));
      chk("wr_ramstore", 64'(g_store), 64'(32'hDEAD_BEEF));
      chk("wr_dload", 64'(last_dload), 64'(0));
      issue_d(1'b0, 1'b1, 32'h0000_0200, '0);
      repeat (5) step();
      chk("wr_readback", 64'(last_dload), 64'(32'hDEAD_BEEF));

      // requester drops its read mid-grant: hit still delivered
      ram_lat = 3; bd = d_hits;
      issue_d(1'b0, 1'b1, 32'h0000_010C, '0);
      repeat (2) step();
      bus.dREN = 1'b0;
      repeat (5) step();
      chk("drop_still_hits", 64'(d_hits - bd), 64'(1));

      // timeout with RAM stuck BUSY
      ram_mode = 1; err_expected = 1'b1; bi = i_hits; bd = d_hits; be = errs;
      issue_d(1'b0, 1'b1, 32'h0000_0104, '0);
      for (int k = 0; k < 300 && errs == be; k++) step();
      chk("tmo_err", 64'(errs - be), 64'(1));
      chk("tmo_wait_cycles", 64'(err_en_len), 64'(TIMEOUT));
      chk("tmo_idle", 64'(bus.ramREN | bus.ramWEN), 64'(0));
      chk("tmo_no_hit", 64'((i_hits - bi) + (d_hits - bd)), 64'(0));
      err_expected = 1'b0; ram_mode = 0;
      repeat (3) step();

      // RAM ERROR aborts on the next cycle
      ram_mode = 2; err_expected = 1'b1; bi = i_hits; be = errs;
      issue_i(32'h0000_0044);
      repeat (2) step();
      chk("err_pulse", 64'(errs - be), 64'(1));
      chk("err_latency", 64'(err_cyc - i_issue_cyc), 64'(2));
      chk("err_no_hit", 64'(i_hits - bi), 64'(0));
      err_expected = 1'b0; ram_mode = 0; ram_lat = 1;
      repeat (3) step();

      // reset mid-grant, then a pending fetch is served normally
      ram_mode = 1;
      issue_d(1'b0, 1'b1, 32'h0000_0108, '0);
      repeat (3) step();
      chk("pre_rst_in_grant", 64'(bus.ramREN), 64'(1));
      #2 n_rst = 1'b0;
      #1;
      chk("midrst_ram", 64'({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}), 64'(0));
      chk("midrst_hits", 64'({bus.ihit, bus.dhit, bus.mem_err}), 64'(0));
      chk("midrst_loads", 64'({bus.iload, bus.dload}), 64'(0));
      bus.dREN = 1'b0;
      ram_mode = 0; ram_lat = 1;
      streak = 0; prev_en = 1'b0; gr = 0; last_iload = '0; last_dload = '0;
      issue_i(32'h0000_0048);
      @(negedge clk);
      n_rst = 1'b1;
      bi = i_hits; bd = d_hits; be = errs;
      repeat (6) step();
      chk("post_rst_ihit", 64'(i_hits - bi), 64'(1));
      chk("post_rst_quiet", 64'((d_hits - bd) + (errs - be)), 64'(0));

      // random mixed traffic
      rand_on = 1'b1;
      repeat (400) step();
      rand_on = 1'b0;
      repeat (30) step();
      chk("drain", 64'(bus.iREN | bus.dREN | bus.dWEN), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined core.
- Latches one request at a time, sequences it to RAM, and returns a one-cycle ihit/dhit pulse that the hazard unit consumes for stall/flush decisions.
- Data requests normally win; an anti-starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data word width
- STARVE_MAX, 4, consecutive data grants allowed while iREN is pending before fetch is forced
- TIMEOUT, 255, max cycles in a grant state without RAM ACCESS before abort

Ports:
- CLK  input  1  clock, rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  fetch read request, held until ihit
- iaddr  input  ADDR_W  fetch address
- ihit  output  1  fetch complete, one-cycle pulse
- iload  output  DATA_W  fetch data, valid when ihit=1
- dREN  input  1  data read request, held until dhit
- dWEN  input  1  data write request, held until dhit
- daddr  input  ADDR_W  data address
- dstore  input  DATA_W  write data
- dhit  output  1  data access complete, one-cycle pulse
- dload  output  DATA_W  read data, valid when dhit=1 on a read
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  ADDR_W  RAM address
- ramstore  output  DATA_W  RAM write data
- ramload  input  DATA_W  RAM read data
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- mem_err  output  1  abort pulse (timeout or ERROR)

Behaviour:
- Reset (nRST=0, async): state=IDLE. All outputs 0; starve_cnt=0; timeout counter=0. Reset during a grant aborts it with no hit and no mem_err.
- States: IDLE, IGRANT, DGRANT.
- IDLE arbitration (registered, takes effect next edge):
  - (dREN|dWEN) and not (iREN and starve_cnt==STARVE_MAX) -> DGRANT; starve_cnt increments if iREN, else clears.
  - else iREN -> IGRANT; starve_cnt=0.
  - else stay in IDLE.
- On grant, latch address, direction and store data into registers. RAM outputs drive only from the latched copy; requester changes during a grant are ignored.
- dREN and dWEN both high is treated as a write.
- In a grant state, ramREN/ramWEN are held until ramstate==ACCESS is sampled.
- ACCESS sampled at edge N:
  - at edge N, drop RAM enables; return to IDLE;
  - in cycle N+1, pulse ihit or dhit for exactly one cycle, with iload/dload = ramload registered at N;
  - dload=0 on a write.
- Minimum latency: request seen at edge 0, grant at 1, ACCESS at 1 at the earliest, hit in cycle 2. At most one hit per two cycles per requester.
- ihit and dhit are never high in the same cycle.
- iload/dload hold their value until the next hit of the same port.
- A requester that drops its request mid-grant still receives its hit pulse; the hazard unit ignores it.
- ramstate==ERROR, or TIMEOUT cycles in a grant without ACCESS -> IDLE, mem_err one-cycle pulse, no hit. The requester re-arbitrates normally on its next request.
- starve_cnt saturates at STARVE_MAX and never wraps. The timeout counter clears on entry to each grant.
- FREE/BUSY in a grant state are treated as wait.

Decomposition:
- cpu_types_pkg holds ramstate_t (FREE, BUSY, ACCESS, ERROR), word_t, and the arbiter state enum arb_state_t.
- Single module with no sub-module; the grant FSM and the latched request register are small enough to keep together.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x0000_0040; RAM returns ACCESS 2 cycles after ramREN with ramload=0x2001_0005 -> ramREN high for 2 cycles, ihit pulses once with iload=0x2001_0005, dhit=0.
- Simultaneous iREN and dREN at edge 0 (daddr=0x100) -> DGRANT first; dhit, then ihit no earlier than 2 cycles later; never both high together.
- Starvation: dREN held continuously and iREN held, STARVE_MAX=4 -> after 4 dhit pulses, the 5th grant is IGRANT and ihit pulses.
- Write: dWEN=1, daddr=0x200, dstore=0xDEAD_BEEF -> ramWEN=1, ramaddr=0x200, ramstore=0xDEAD_BEEF; dhit pulses with dload=0.
- Timeout and error:
  - ramstate stuck BUSY, TIMEOUT=255 -> mem_err pulses 255 cycles after grant, no hit, state returns to IDLE.
  - ramstate=ERROR -> mem_err on the next cycle.
- Reset mid-grant: deassert nRST while in DGRANT -> all outputs 0 immediately; after release, a pending iREN is granted normally.
